// File: rtl/wb_stage.sv
// wb_stage: writeback stage issuing one register-file write per retired instruction.
// Define WB_INSTRET_EN to add a 64-bit retired-instruction counter output (instret).
module wb_stage #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic                  in_wen,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic                  in_is_load,
    input  logic [2:0]            in_ld_funct3,
    input  logic [1:0]            in_addr_lo,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_rready,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  commit,
    output logic                  busy
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]           instret
`endif
);
    typedef enum logic [1:0] {IDLE, WAIT_MEM, COMMIT} state_e;
    state_e                state_q;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic                  wen_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [2:0]            funct3_q;
    logic [1:0]            addr_lo_q;
    logic                  commit_q;
    logic                  rf_wen_q;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_d;

    // Unlisted funct3 codes fall through to the raw word.
    always_comb begin
        byte_sel = 8'(mem_rdata >> {addr_lo_q, 3'b000});
        half_sel = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_d   = funct3_q == 3'b000 ? {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel} :
                   funct3_q == 3'b001 ? {{(DATA_WIDTH-16){half_sel[15]}}, half_sel} :
                   funct3_q == 3'b100 ? {{(DATA_WIDTH-8){1'b0}}, byte_sel} :
                   funct3_q == 3'b101 ? {{(DATA_WIDTH-16){1'b0}}, half_sel} : mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_q      <= '0;
            wen_q     <= 1'b0;
            data_q    <= '0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            commit_q  <= 1'b0;
            rf_wen_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    rd_q      <= in_rd;
                    wen_q     <= in_wen;
                    data_q    <= in_result;
                    funct3_q  <= in_ld_funct3;
                    addr_lo_q <= in_addr_lo;
                    state_q   <= in_is_load ? WAIT_MEM : COMMIT;
                    commit_q  <= !in_is_load;
                    rf_wen_q  <= !in_is_load && in_wen && (in_rd != '0);
                end
                WAIT_MEM: if (mem_rvalid) begin
                    data_q   <= load_d;
                    state_q  <= COMMIT;
                    commit_q <= 1'b1;
                    rf_wen_q <= wen_q && (rd_q != '0);
                end
                COMMIT: begin
                    state_q  <= IDLE;
                    commit_q <= 1'b0;
                    rf_wen_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) instret_q <= '0;
        else if (commit_q) instret_q <= instret_q + 64'd1;
    end
    assign instret = instret_q;
`endif

    assign in_ready   = state_q == IDLE;
    assign mem_rready = state_q == WAIT_MEM;
    assign busy       = state_q != IDLE;
    assign commit     = commit_q;
    assign rf_wen     = rf_wen_q;
    assign rf_waddr   = rd_q;
    assign rf_wdata   = data_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table-driven directed vectors plus reset and idle corner sequences for wb_stage.
module tb_wb_stage;
    logic        clk = 0, rst = 1;
    logic        in_valid = 0, in_wen = 0, in_is_load = 0, mem_rvalid = 0;
    logic [4:0]  in_rd = 0;
    logic [31:0] in_result = 0, mem_rdata = 0;
    logic [2:0]  in_ld_funct3 = 0;
    logic [1:0]  in_addr_lo = 0;
    logic        in_ready, mem_rready, rf_wen, commit, busy;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    int          n_cmp = 0, n_fail = 0, exp_ret = 0;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    wb_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
        .in_wen(in_wen), .in_result(in_result), .in_is_load(in_is_load),
        .in_ld_funct3(in_ld_funct3), .in_addr_lo(in_addr_lo), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .mem_rready(mem_rready), .rf_wen(rf_wen), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .commit(commit), .busy(busy)
`ifdef WB_INSTRET_EN
        , .instret(instret)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_load;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] result;
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
        logic [31:0] rdata;
        int          delay;
        logic        exp_wen;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        chk({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
        in_valid = 1; in_rd = v.rd; in_wen = v.wen; in_result = v.result;
        in_is_load = v.is_load; in_ld_funct3 = v.funct3; in_addr_lo = v.addr_lo;
        @(posedge clk); #1;
        in_valid = 0; in_result = 32'h5555_AAAA; in_rd = 5'd31;
        if (v.is_load) begin
            for (int i = 0; i < v.delay; i++) begin
                chk({tag, "_waitmem"}, {61'd0, busy, mem_rready, commit}, 64'b110);
                @(posedge clk); #1;
            end
            @(negedge clk);
            mem_rvalid = 1; mem_rdata = v.rdata;
            @(posedge clk); #1;
            mem_rvalid = 0; mem_rdata = 32'hDEAD_0000;
        end
        chk({tag, "_commit"}, {26'd0, commit, rf_wen, rf_waddr, rf_wdata},
            {26'd0, 1'b1, v.exp_wen, v.rd, v.exp_wdata});
        chk({tag, "_busy_in_commit"}, {62'd0, busy, in_ready}, 64'b10);
        exp_ret++;
        @(posedge clk); #1;
        chk({tag, "_back_idle"}, {61'd0, in_ready, commit, rf_wen}, 64'b100);
    endtask

    initial begin
        vecs[0]  = '{0, 5'd5, 1, 32'hDEADBEEF, 3'b000, 2'd0, 32'h0, 0, 1, 32'hDEADBEEF};
        vecs[1]  = '{0, 5'd0, 1, 32'h00001234, 3'b000, 2'd0, 32'h0, 0, 0, 32'h00001234};
        vecs[2]  = '{0, 5'd7, 0, 32'hCAFEF00D, 3'b000, 2'd0, 32'h0, 0, 0, 32'hCAFEF00D};
        vecs[3]  = '{1, 5'd9, 1, 32'h0, 3'b000, 2'd3, 32'h80FF7F01, 4, 1, 32'hFFFFFF80};
        vecs[4]  = '{1, 5'd10, 1, 32'h0, 3'b101, 2'd2, 32'h80FF7F01, 0, 1, 32'h000080FF};
        vecs[5]  = '{1, 5'd11, 1, 32'h0, 3'b001, 2'd2, 32'h80FF7F01, 1, 1, 32'hFFFF80FF};
        vecs[6]  = '{1, 5'd12, 1, 32'h0, 3'b100, 2'd0, 32'h80FF7F01, 0, 1, 32'h00000001};
        vecs[7]  = '{1, 5'd13, 1, 32'h0, 3'b000, 2'd1, 32'h80FF7F01, 2, 1, 32'h0000007F};
        vecs[8]  = '{1, 5'd14, 1, 32'h0, 3'b000, 2'd2, 32'h80FF7F01, 0, 1, 32'hFFFFFFFF};
        vecs[9]  = '{1, 5'd15, 1, 32'h0, 3'b001, 2'd0, 32'h80FF7F01, 0, 1, 32'h00007F01};
        vecs[10] = '{1, 5'd16, 1, 32'h0, 3'b010, 2'd1, 32'h80FF7F01, 0, 1, 32'h80FF7F01};
        vecs[11] = '{1, 5'd17, 1, 32'h0, 3'b011, 2'd3, 32'h80FF7F01, 0, 1, 32'h80FF7F01};
        vecs[12] = '{1, 5'd18, 1, 32'h0, 3'b100, 2'd3, 32'h80FF7F01, 0, 1, 32'h00000080};
        vecs[13] = '{1, 5'd19, 1, 32'h0, 3'b101, 2'd0, 32'h80FF7F01, 0, 1, 32'h00007F01};
        vecs[14] = '{1, 5'd0, 1, 32'h0, 3'b010, 2'd0, 32'h12345678, 0, 0, 32'h12345678};
        vecs[15] = '{1, 5'd20, 0, 32'h0, 3'b110, 2'd0, 32'h0BADF00D, 0, 0, 32'h0BADF00D};

        #1;
        chk("reset_outputs", {24'd0, rf_wen, rf_waddr, rf_wdata, commit, mem_rready, busy}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 0;
        #1 chk("ready_after_reset", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);
`ifdef WB_INSTRET_EN
        chk("instret_all", instret, 64'(exp_ret));
`endif

        // Idle: mem_rvalid without a pending load must be ignored.
        @(negedge clk); mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
        repeat (3) begin
            @(posedge clk); #1;
            chk("idle_rvalid", {59'd0, mem_rready, busy, commit, rf_wen, in_ready}, 64'b00001);
        end
        @(negedge clk); mem_rvalid = 0;

        // Reset in WAIT_MEM drops the load; a late rvalid is ignored.
        @(negedge clk);
        in_valid = 1; in_is_load = 1; in_rd = 5'd3; in_wen = 1; in_result = 32'h0000ABCD;
        in_ld_funct3 = 3'b010; in_addr_lo = 0;
        @(posedge clk); #1; in_valid = 0;
        chk("load_pending", {62'd0, mem_rready, busy}, 64'b11);
        @(posedge clk);
        @(negedge clk); rst = 1;
        #1 chk("mid_load_reset", {24'd0, rf_wen, rf_waddr, rf_wdata, commit, mem_rready, busy}, 64'd0);
        exp_ret = 0;
        @(negedge clk); rst = 0; mem_rvalid = 1; mem_rdata = 32'h7777_7777;
        repeat (3) begin
            @(posedge clk); #1;
            chk("late_rvalid", {59'd0, mem_rready, busy, commit, rf_wen, in_ready}, 64'b00001);
        end
        @(negedge clk); mem_rvalid = 0;

        for (int i = 0; i < 4; i++) run_vec(100 + i, vecs[i]);
`ifdef WB_INSTRET_EN
        chk("instret_3alu_1load", instret, 64'd4);
`endif
        chk("instret_model_count", 64'(exp_ret), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
